// File: rtl/div_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pipe_pkg
//  Purpose  : Shared types and constants for the RV32M divide execution pipe.
//  Revision : 1.0  initial release
// ============================================================================
package div_pipe_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DIV_NUM_ITER    = 32;
  // Lowest fixed writeback priority among the execution pipes
  localparam int unsigned EXE_PIPE_ID_DIV = 3;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1;          // dividend
    logic [XLEN-1:0] rs2;          // divisor
    div_op_e         div_control;
  } ix_div_inf_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } div_wb_inf_t;

  // Two's complement magnitude; 0x80000000 maps to itself read as unsigned
  function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic is_signed_op(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module   : div_pipe_core
//  Purpose  : Unsigned restoring shift-subtract iterator, one quotient bit
//             per cycle, DIV_NUM_ITER cycles per operation.
//  Revision : 1.0  initial release
// ============================================================================
module div_pipe_core #(
  parameter int DIV_NUM_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  localparam int CNT_W = $clog2(DIV_NUM_ITER);

  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dsr;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  logic [32:0]      r_sh;
  logic [32:0]      diff;
  logic             take;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    r_sh = {rem, quo[31]};
    diff = r_sh - {1'b0, dsr};
    take = ~diff[32];
  end

  // Final step of the current operation completes on this edge
  assign last      = busy & (cnt == CNT_W'(DIV_NUM_ITER - 1));
  assign quotient  = quo;
  assign remainder = rem;

  // Iteration registers; counter wraps back to zero after the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= dividend;
      dsr  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= take ? diff[31:0] : r_sh[31:0];
      quo  <= {quo[30:0], take};
      cnt  <= cnt + 1'b1;
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : div_pipe
//  Purpose  : RV32M DIV/DIVU/REM/REMU execution pipe. Handles signs, the
//             divide-by-zero and overflow early exits, and the IX/WB
//             handshakes around the unsigned iterator.
//  Revision : 1.0  initial release
// ============================================================================
module div_pipe
  import div_pipe_pkg::*;
#(
  parameter int DIV_NUM_ITER = div_pipe_pkg::DIV_NUM_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ix_div_valid,
  input  ix_div_inf_t ix_div_inf,
  output logic        div_ready,
  output logic        div_wb_valid,
  input  logic        wb_div_ready,
  output div_wb_inf_t div_wb_inf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  rd;
  div_op_e     op;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic        in_signed;
  logic        in_div0;
  logic        in_ovf;
  logic        in_special;
  logic [31:0] in_special_res;
  logic [31:0] in_mag1;
  logic [31:0] in_mag2;

  logic [31:0] core_q;
  logic [31:0] core_r;
  logic        core_last;
  logic [31:0] fixed_res;

  // Ready depends only on state and WB, so IX can never form a loop through it
  assign div_ready    = (state == ST_IDLE) | ((state == ST_DONE) & wb_div_ready);
  assign div_wb_valid = (state == ST_DONE);
  assign accept       = ix_div_valid & div_ready;

  // Decode of the incoming operation: operand magnitudes and early exits
  always_comb begin
    in_signed      = is_signed_op(ix_div_inf.div_control);
    in_div0        = (ix_div_inf.rs2 == 32'h0);
    in_ovf         = in_signed && (ix_div_inf.rs1 == 32'h8000_0000) &&
                     (ix_div_inf.rs2 == 32'hFFFF_FFFF);
    in_special     = in_div0 | in_ovf;
    in_mag1        = in_signed ? mag32(ix_div_inf.rs1) : ix_div_inf.rs1;
    in_mag2        = in_signed ? mag32(ix_div_inf.rs2) : ix_div_inf.rs2;
    in_special_res = 32'h0;
    if (in_div0) begin
      in_special_res = is_rem_op(ix_div_inf.div_control) ? ix_div_inf.rs1 : 32'hFFFF_FFFF;
    end else if (in_ovf) begin
      in_special_res = is_rem_op(ix_div_inf.div_control) ? 32'h0 : 32'h8000_0000;
    end
  end

  // Sign correction of the unsigned iterator outputs
  always_comb begin
    fixed_res = is_rem_op(op) ? (neg_r ? (~core_r + 1'b1) : core_r)
                              : (neg_q ? (~core_q + 1'b1) : core_q);
  end

  div_pipe_core #(
    .DIV_NUM_ITER (DIV_NUM_ITER)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & ~in_special),
    .dividend  (in_mag1),
    .divisor   (in_mag2),
    .quotient  (core_q),
    .remainder (core_r),
    .last      (core_last)
  );

  // Control FSM; acceptance is shared by IDLE and the DONE handoff cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd         <= '0;
      op         <= DIV_OP_DIV;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_wb_inf <= '0;
    end else if (accept) begin
      rd    <= ix_div_inf.rd;
      op    <= ix_div_inf.div_control;
      neg_q <= in_signed & (ix_div_inf.rs1[31] ^ ix_div_inf.rs2[31]);
      neg_r <= in_signed & ix_div_inf.rs1[31];
      if (in_special) begin
        div_wb_inf.rd     <= ix_div_inf.rd;
        div_wb_inf.result <= in_special_res;
        state             <= ST_DONE;
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          if (core_last) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          div_wb_inf.rd     <= rd;
          div_wb_inf.result <= fixed_res;
          state             <= ST_DONE;
        end
        ST_DONE: begin
          if (wb_div_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_pipe
//  Purpose  : Scoreboard bench for div_pipe against a plain-arithmetic
//             RV32M divide model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_pipe;
  import div_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ix_div_valid = 1'b0;
  ix_div_inf_t ix_div_inf = '0;
  logic        div_ready;
  logic        div_wb_valid;
  logic        wb_div_ready = 1'b1;
  div_wb_inf_t div_wb_inf;

  div_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .div_ready    (div_ready),
    .div_wb_valid (div_wb_valid),
    .wb_div_ready (wb_div_ready),
    .div_wb_inf   (div_wb_inf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   bp_mode = 0;   // 0 always ready, 1 random, 2 held low

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (bp_mode)
      0:       wb_div_ready = 1'b1;
      1:       wb_div_ready = ($urandom_range(0, 3) != 0);
      default: wb_div_ready = 1'b0;
    endcase
  end

  // RV32M semantics straight from the ISA rules
  function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb2;
    sa  = a;
    sb2 = b;
    case (op)
      DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_OP_REMU: return (b == 0) ? a : a % b;
      DIV_OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb2;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb2;
      end
    endcase
  endfunction

  function automatic int ref_latency(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int   waited;
    exp_t e;
    ix_div_inf.rd          = rd;
    ix_div_inf.rs1         = a;
    ix_div_inf.rs2         = b;
    ix_div_inf.div_control = op;
    ix_div_valid           = 1'b1;
    waited = 0;
    #1;
    while (!div_ready) begin
      if (waited > 300) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout got div_ready=0 for %0d cycles want 1", waited);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "accept timeout");
      end
      @(negedge clk);
      #1;
      waited++;
    end
    e.rd  = rd;
    e.res = ref_result(op, a, b);
    e.acc = cyc + 1;
    e.lat = ref_latency(op, a, b);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ix_div_valid = 1'b0;
  endtask

  // Monitor: latency on first appearance, stability under backpressure,
  // value check on transfer
  logic        prev_valid = 1'b0;
  logic        prev_taken = 1'b0;
  div_wb_inf_t prev_inf = '0;
  exp_t        me;
  int          mlat;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_taken = 1'b0;
    end else begin
      if (div_wb_valid) begin
        if (prev_valid && !prev_taken) begin
          tests++;
          if (div_wb_inf !== prev_inf) begin
            fails++;
            $display("FAIL hold_stable got %h want %h", div_wb_inf, prev_inf);
          end
        end else if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result got rd=%0d result=%h want no output", div_wb_inf.rd, div_wb_inf.result);
        end else begin
          tests++;
          mlat = cyc + 1 - sb[0].acc;
          if (mlat != sb[0].lat) begin
            fails++;
            $display("FAIL latency got %0d want %0d", mlat, sb[0].lat);
          end
        end
        if (wb_div_ready && sb.size() != 0) begin
          me = sb.pop_front();
          tests++;
          if (div_wb_inf.rd !== me.rd || div_wb_inf.result !== me.res) begin
            fails++;
            $display("FAIL result got rd=%0d res=%h want rd=%0d res=%h",
                     div_wb_inf.rd, div_wb_inf.result, me.rd, me.res);
          end
        end
      end
      prev_valid = div_wb_valid;
      prev_taken = div_wb_valid & wb_div_ready;
      prev_inf   = div_wb_inf;
    end
  end

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int waited;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_bit("reset_valid", div_wb_valid, 1'b0);
    check_bit("reset_ready", div_ready, 1'b1);
    tests++;
    if (div_wb_inf !== '0) begin
      fails++;
      $display("FAIL reset_inf got %h want 0", div_wb_inf);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases
    @(negedge clk);
    issue(DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE, 5'd3);
    issue(DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,         5'd4);
    issue(DIV_OP_REMU, 32'hFFFF_FFF9,  32'd2,         5'd5);
    issue(DIV_OP_DIVU, 32'hFFFF_FFF9,  32'd2,         5'd6);
    issue(DIV_OP_DIVU, 32'd100,        32'd0,         5'd7);
    issue(DIV_OP_REM,  32'd100,        32'd0,         5'd8);
    issue(DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd0);
    issue(DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd31);
    repeat (40) @(negedge clk);

    // Backpressure: hold DONE for 5 cycles with a new op pending
    bp_mode = 2;
    @(negedge clk);
    issue(DIV_OP_DIVU, 32'd1000, 32'd7, 5'd9);
    waited = 0;
    #2;
    while (!div_wb_valid && waited < 60) begin
      @(negedge clk);
      #2;
      waited++;
    end
    check_bit("hold_reached_done", div_wb_valid, 1'b1);
    ix_div_inf.rd          = 5'd10;
    ix_div_inf.rs1         = 32'hFFFF_FF00;
    ix_div_inf.rs2         = 32'd3;
    ix_div_inf.div_control = DIV_OP_DIV;
    ix_div_valid           = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_bit("hold_ready_low", div_ready, 1'b0);
      check_bit("hold_valid_high", div_wb_valid, 1'b1);
      @(negedge clk);
      #2;
    end
    bp_mode = 0;
    @(negedge clk);
    issue(DIV_OP_DIV, 32'hFFFF_FF00, 32'd3, 5'd10);
    repeat (40) @(negedge clk);

    // Reset in the middle of CALC drops the operation
    issue(DIV_OP_DIVU, 32'hDEAD_BEEF, 32'd13, 5'd11);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    #2;
    check_bit("midreset_valid", div_wb_valid, 1'b0);
    check_bit("midreset_ready", div_ready, 1'b1);
    tests++;
    if (div_wb_inf !== '0) begin
      fails++;
      $display("FAIL midreset_inf got %h want 0", div_wb_inf);
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #2;
    check_bit("midreset_no_stale", div_wb_valid, 1'b0);

    // Randomized operations with random backpressure
    bp_mode = 1;
    @(negedge clk);
    for (int n = 0; n < 60; n++) begin
      issue(div_op_e'($urandom_range(0, 3)), pick(), pick(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // Drain
    bp_mode = 0;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
